// File: rtl/conv_x_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_stream_pkg
//  Purpose  : Shared types and helpers for the convolution stream feeders.
//             - state_t        : streamer control states
//             - word_t         : default signed stream word
//             - frames_or_one  : frame-count rule (0 requests one frame)
//  Revision : 1.0  initial release
// ============================================================================
package conv_stream_pkg;

    localparam int WORD_W = 16;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_SEND  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // A requested frame count of zero still sends the vector once.
    function automatic logic [15:0] frames_or_one(input logic [15:0] n);
        return (n == 16'd0) ? 16'd1 : n;
    endfunction

endpackage : conv_stream_pkg
`default_nettype wire

// File: rtl/sp_sync_ram.sv
`default_nettype none
// ============================================================================
//  Module   : sp_sync_ram
//  Purpose  : Single-port synchronous RAM, read-first, one-cycle read latency.
//  Ports    : clk            clock
//             we             write enable
//             addr [ADDR_W]  shared read/write address
//             wdata[WIDTH]   write data
//             rdata[WIDTH]   registered read data (mem[addr] of previous edge)
//  Revision : 1.0  initial release
// ============================================================================
module sp_sync_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule : sp_sync_ram
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : stream_skid_buf
//  Purpose  : Two-entry valid/ready output buffer. The producer pushes only
//             when it knows a slot is free (it watches occupancy), so there
//             is no input ready. out_valid comes from a register only.
//  Ports    : clk, reset          clock, synchronous active-high reset
//             in_valid, in_data   push side
//             out_valid, out_data, out_ready   stream side
//             occupancy[2]        entries currently held (0..2)
//  Revision : 1.0  initial release
// ============================================================================
module stream_skid_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_entry [2];
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_cnt;
    logic             w_pop;

    assign w_pop     = out_valid && out_ready;
    assign out_valid = (r_cnt != 2'd0);
    // Empty buffer presents zero so x_data is clean out of reset.
    assign out_data  = out_valid ? r_entry[r_rp] : '0;
    assign occupancy = r_cnt;

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_entry[r_wp] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (in_valid) begin
                r_wp <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, in_valid} - {1'b0, w_pop};
        end
    end

endmodule : stream_skid_buf
`default_nettype wire

// File: rtl/conv_x_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_x_streamer
//  Purpose  : Holds one DEPTH-word vector loaded over ld_*, then replays it
//             num_frames times (0 -> 1) on the x_* valid/ready stream.
//  Ports    : clk, reset                      clock, sync active-high reset
//             ld_data, ld_valid, ld_ready     vector load port (LOAD only)
//             reload, start, num_frames       control (honoured in READY)
//             loaded, busy, done              status
//             x_data, x_valid, x_ready        output stream
//  Revision : 1.0  initial release
// ============================================================================
module conv_x_streamer
    import conv_stream_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int FRAME_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ld_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic                     reload,
    input  logic                     start,
    input  logic [FRAME_W-1:0]       num_frames,
    output logic                     loaded,
    output logic                     busy,
    output logic                     done,
    output logic signed [WIDTH-1:0]  x_data,
    output logic                     x_valid,
    input  logic                     x_ready
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [FRAME_W-1:0]  r_frame_cnt;
    logic [FRAME_W-1:0]  r_frames;
    logic                r_rd_pending;
    logic                r_done;

    logic                w_ld_fire;
    logic                w_pop;
    logic                w_issue;
    logic                w_last_word;
    logic                w_drain_done;
    logic [1:0]          w_occ;
    logic [2:0]          w_slots;
    logic [PTR_W-1:0]    w_addr;
    logic [WIDTH-1:0]    w_rdata;
    logic [WIDTH-1:0]    w_buf_data;

    assign w_ld_fire = (r_state == ST_LOAD) && ld_valid;
    assign w_pop     = x_valid && x_ready;

    // Slots committed after this cycle: buffered + in-flight read - word
    // leaving now. A read may be issued whenever that leaves room for it.
    assign w_slots   = {1'b0, w_occ} + {2'b0, r_rd_pending} - {2'b0, w_pop};
    assign w_issue   = (r_state == ST_SEND) && (w_slots < 3'd2);

    assign w_last_word  = (r_rd_ptr == LAST_IDX) && (r_frame_cnt == r_frames - FRAME_ONE);
    assign w_drain_done = (r_state == ST_DRAIN) && w_pop && (w_occ == 2'd1) && !r_rd_pending;

    assign w_addr = (r_state == ST_LOAD) ? r_wr_ptr : r_rd_ptr;

    sp_sync_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_vec_mem (
        .clk   (clk),
        .we    (w_ld_fire),
        .addr  (w_addr),
        .wdata (ld_data),
        .rdata (w_rdata)
    );

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_rd_pending),
        .in_data   (w_rdata),
        .out_valid (x_valid),
        .out_data  (w_buf_data),
        .out_ready (x_ready),
        .occupancy (w_occ)
    );

    assign x_data = w_buf_data;
    assign done   = r_done;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_ld_fire && (r_wr_ptr == LAST_IDX)) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (start) begin
                    w_state_next = ST_SEND;
                end else if (reload) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_SEND: begin
                if (w_issue && w_last_word) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_next = ST_READY;
                end
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        ld_ready = 1'b0;
        loaded   = 1'b0;
        busy     = 1'b0;
        case (r_state)
            ST_LOAD:  ld_ready = 1'b1;
            ST_READY: loaded   = 1'b1;
            ST_SEND:  busy     = 1'b1;
            ST_DRAIN: busy     = 1'b1;
            default:  ld_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_frame_cnt  <= '0;
            r_frames     <= FRAME_ONE;
            r_rd_pending <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_ld_fire) begin
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
            end

            if ((r_state == ST_READY) && start) begin
                r_rd_ptr    <= '0;
                r_frame_cnt <= '0;
                r_frames    <= FRAME_W'(frames_or_one(16'(num_frames)));
            end else if (w_issue) begin
                if (r_rd_ptr == LAST_IDX) begin
                    r_rd_ptr    <= '0;
                    r_frame_cnt <= r_frame_cnt + FRAME_ONE;
                end else begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end

            r_rd_pending <= w_issue;
            r_done       <= w_drain_done;
        end
    end

endmodule : conv_x_streamer
`default_nettype wire

// File: tb/tb_conv_x_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_x_streamer
//  Purpose  : Directed self-checking bench for conv_x_streamer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_x_streamer;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 16;
    localparam int FRAME_W = 4;
    localparam int BUDGET  = 400;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [WIDTH-1:0]        ld_data;
    logic                    ld_valid;
    logic                    ld_ready;
    logic                    reload;
    logic                    start;
    logic [FRAME_W-1:0]      num_frames;
    logic                    loaded;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] x_data;
    logic                    x_valid;
    logic                    x_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [WIDTH-1:0] vec [DEPTH];

    always #5 clk = ~clk;

    conv_x_streamer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .reload     (reload),
        .start      (start),
        .num_frames (num_frames),
        .loaded     (loaded),
        .busy       (busy),
        .done       (done),
        .x_data     (x_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec();
        for (int i = 0; i < DEPTH; i++) begin
            chk("ld_ready_in_load", 32'(ld_ready), 32'd1);
            chk("loaded_in_load", 32'(loaded), 32'd0);
            ld_valid = 1'b1;
            ld_data  = vec[i];
            tick();
        end
        ld_valid = 1'b0;
        chk("loaded_after_16", 32'(loaded), 32'd1);
        chk("ld_ready_after_16", 32'(ld_ready), 32'd0);
    endtask

    // mode 0: x_ready always 1; mode 1: x_ready pattern 1,0,0,1 repeating
    task automatic stream(input int frames_in, input int nfr, input int mode, input bit with_reload);
        int                      idx;
        int                      cyc;
        int                      total;
        bit                      rdy;
        bit                      prev_stall;
        logic signed [WIDTH-1:0] prev_data;

        total      = nfr * DEPTH;
        idx        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;

        x_ready    = 1'b0;
        num_frames = FRAME_W'(frames_in);
        start      = 1'b1;
        reload     = with_reload;
        tick();                                    // edge k
        start  = 1'b0;
        reload = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_k1_low", 32'(x_valid), 32'd0);
        tick();                                    // edge k+1
        chk("valid_k1_still_low", 32'(x_valid), 32'd0);
        tick();                                    // edge k+2
        chk("valid_k2_high", 32'(x_valid), 32'd1);
        chk("first_word", 32'(x_data), 32'(vec[0]));

        while ((idx < total) && (cyc < BUDGET)) begin
            rdy     = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            x_ready = rdy;
            if (prev_stall) begin
                chk("stall_valid_held", 32'(x_valid), 32'd1);
                chk("stall_data_stable", 32'(x_data), 32'(prev_data));
            end
            if (mode == 0) begin
                chk("no_bubble", 32'(x_valid), 32'd1);
            end
            chk("busy_while_streaming", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (x_valid && rdy) begin
                chk("word_order", 32'(x_data), 32'(vec[idx % DEPTH]));
                idx++;
            end
            prev_stall = x_valid && !rdy;
            prev_data  = x_data;
            tick();
            cyc++;
        end
        x_ready = 1'b0;
        chk("transfer_count", 32'(idx), 32'(total));
        chk("done_pulse", 32'(done), 32'd1);
        chk("loaded_after_stream", 32'(loaded), 32'd1);
        chk("busy_after_stream", 32'(busy), 32'd0);
        chk("valid_after_stream", 32'(x_valid), 32'd0);
        tick();
        chk("done_single", 32'(done), 32'd0);
        chk("no_extra_word", 32'(x_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        ld_valid   = 1'b0;
        ld_data    = '0;
        reload     = 1'b0;
        start      = 1'b0;
        num_frames = '0;
        x_ready    = 1'b0;
        tick();
        tick();
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_x_data", 32'(x_data), 32'd0);
        reset = 1'b0;
        tick();

        // start while still loading is ignored
        num_frames = FRAME_W'(1);
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_load_busy", 32'(busy), 32'd0);
        chk("start_in_load_ld_ready", 32'(ld_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) vec[i] = WIDTH'(i);
        load_vec();

        stream(1, 1, 0, 1'b0);
        stream(3, 3, 0, 1'b0);
        stream(2, 2, 1, 1'b0);
        stream(0, 1, 0, 1'b0);
        stream(1, 1, 0, 1'b1);      // start and reload together: start wins

        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_ld_ready", 32'(ld_ready), 32'd1);
        chk("reload_loaded", 32'(loaded), 32'd0);
        for (int i = 0; i < DEPTH; i++) vec[i] = WIDTH'(-(i + 1));
        load_vec();
        stream(1, 1, 1, 1'b0);

        // reset after five transfers mid-stream
        num_frames = FRAME_W'(1);
        start      = 1'b1;
        tick();
        start   = 1'b0;
        x_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_word", 32'(x_data), 32'(vec[5]));
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        x_ready = 1'b0;
        chk("midrst_x_valid", 32'(x_valid), 32'd0);
        chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_loaded", 32'(loaded), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrst_start_ignored_busy", 32'(busy), 32'd0);
        chk("midrst_start_ignored_valid", 32'(x_valid), 32'd0);
        for (int i = 0; i < DEPTH; i++) vec[i] = WIDTH'(3 * i + 100);
        load_vec();
        stream(2, 2, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_conv_x_streamer
`default_nettype wire

// File: doc/conv_x_streamer.md
Name: conv_x_streamer

Overview:
Transmit-side counterpart of the streaming convolution layers: holds one DEPTH-word input vector and streams it out over an x_data/x_valid/x_ready handshake into a conv layer's x port. A host-side load port fills the vector; a start pulse then replays it NUM-frames times at up to one word per cycle under full backpressure. Used in layer test harnesses and as the feeder in front of the first conv stage.

Parameters:
WIDTH, 16, data word width (signed)
DEPTH, 16, words per vector; must match the consuming layer's X
FRAME_W, 4, width of the frame-count input

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ld_data  in  WIDTH  vector word to store
ld_valid  in  1  ld_data valid
ld_ready  out  1  high only in LOAD
reload  in  1  pulse: discard stored vector, return to LOAD (honoured only in READY)
start  in  1  pulse: begin streaming (honoured only in READY)
num_frames  in  FRAME_W  frames to send, sampled with start; 0 treated as 1
loaded  out  1  high in READY
busy  out  1  high in SEND and DRAIN
done  out  1  one-cycle pulse after final word accepted
x_data  out  WIDTH  signed stream word
x_valid  out  1  stream valid
x_ready  in  1  downstream ready

Behaviour:
- Reset: state=LOAD, wr_ptr=0, rd_ptr=0, frame_cnt=0, skid buffer emptied; outputs ld_ready=1, loaded=0, busy=0, done=0, x_valid=0, x_data=0. Memory contents not cleared.
- States: LOAD, READY, SEND, DRAIN.
- LOAD: each ld_valid&&ld_ready writes mem[wr_ptr], wr_ptr++. Write with wr_ptr==DEPTH-1 -> READY, wr_ptr<=0. start/reload ignored.
- READY: start -> SEND, latch max(num_frames,1), rd_ptr=0, frame_cnt=0. reload -> LOAD. start and reload in same cycle: start wins.
- SEND: memory is synchronous-read (1-cycle latency). Reads feed a 2-entry output skid buffer. A read is issued when buffer occupancy plus in-flight read < 2, or when a handshake frees a slot in that cycle. rd_ptr wraps DEPTH-1 -> 0 and frame_cnt increments on wrap. After the read of the last word of the last frame is issued -> DRAIN.
- DRAIN: no new reads. When the last buffered word is accepted -> READY, done=1 for exactly that following cycle. The vector is retained, so start may be reissued.
- Latency: start sampled at edge k; x_valid=1 from after edge k+2; first x_data=mem[0].
- Throughput: with x_ready held 1, one word per cycle with no bubbles, including across frame wrap.
- Handshake: x_valid never drops without a transfer; x_data stable while x_valid&&!x_ready. x_valid does not depend combinationally on x_ready. No word dropped or duplicated under any x_ready pattern.
- Word order: mem[0..DEPTH-1] repeated per frame; total transfers = DEPTH*frames.
- Reset mid-SEND: x_valid falls after the reset edge; state LOAD; partial stream abandoned.
- Single-port memory: address muxes wr_ptr in LOAD and rd_ptr otherwise; write enable only on ld handshake.

Decomposition:
- Package conv_stream_pkg: state enum (LOAD, READY, SEND, DRAIN), word_t = logic signed [WIDTH-1:0], and the 0->1 frame-count rule as a function.
- Sub-module stream_skid_buf: 2-entry valid/ready buffer with in_valid, in_data, out_* and an occupancy output used for read issue.
- Vector store: the team's existing single-port synchronous memory block, WIDTH x DEPTH.

Test Plan:
- Load 0..15 (ld_valid held 1), start with num_frames=1, x_ready=1 -> loaded after 16 writes; x_valid from start+2; x_data 0..15 on consecutive cycles; done pulses once one cycle after word 15.
- Same vector, num_frames=3, x_ready=1 -> 48 transfers, sequence 0..15 x3, no bubble at wraps; busy high throughout; single done.
- num_frames=2, x_ready toggling 1,0,0,1 pattern -> x_data stable during stalls; exactly 32 transfers, correct order, no duplicates.
- num_frames=0 -> treated as 1: 16 transfers, then done.
- Assert start and reload together in READY -> streaming starts; vector unchanged. Then reload alone -> LOAD, ld_ready=1; load -1,-2,... -> new values streamed on next start.
- Reset after 5 transfers in SEND -> x_valid=0 the cycle after the reset edge; ld_ready=1; start ignored until 16 new words are loaded.
